// File: rtl/io_seg_scan.sv
// Time-multiplexed 8-digit common-anode 7-segment scanner for the CPU output ports.
// Shows byte [7:0] of each port as two hex digits. Define SEG_LZB_EN for leading-zero blanking.
module io_seg_scan #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  input  logic [31:0] out_port3,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        frame_start
);

  localparam int unsigned CNT_W = 20;
  localparam int unsigned DIG_W = 3;

  logic [CNT_W-1:0] cnt;
  logic [DIG_W-1:0] dig;
  logic [31:0]      snap;

  logic             tick_c;
  logic             wrap_c;
  logic             blank_c;
  logic [3:0]       nib_c;
  logic [6:0]       hex_c;
  logic [6:0]       seg_c;
  logic             unused_hi_c;

  assign tick_c = (cnt == CNT_W'(CLK_DIV - 1));
  assign wrap_c = tick_c && (dig == DIG_W'(7));
  assign nib_c  = 4'(snap >> {dig, 2'b00});

  // Anti-ghosting window at the start of every digit slot.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign blank_c = 1'b0;
    end else begin : g_blank
      assign blank_c = (cnt < CNT_W'(BLANK_CYC));
    end
  endgenerate

  // Hex to active-low gfedcba.
  always_comb begin
    hex_c = 7'h7F;
    case (nib_c)
      4'h0: hex_c = 7'h40;
      4'h1: hex_c = 7'h79;
      4'h2: hex_c = 7'h24;
      4'h3: hex_c = 7'h30;
      4'h4: hex_c = 7'h19;
      4'h5: hex_c = 7'h12;
      4'h6: hex_c = 7'h02;
      4'h7: hex_c = 7'h78;
      4'h8: hex_c = 7'h00;
      4'h9: hex_c = 7'h10;
      4'hA: hex_c = 7'h08;
      4'hB: hex_c = 7'h03;
      4'hC: hex_c = 7'h46;
      4'hD: hex_c = 7'h21;
      4'hE: hex_c = 7'h06;
      4'hF: hex_c = 7'h0E;
      default: hex_c = 7'h7F;
    endcase
  end

  always_comb begin
    seg_c = hex_c;
`ifdef SEG_LZB_EN
    // Odd digits carry the high nibble of a byte; suppress a leading zero there.
    if (dig[0] && (nib_c == 4'h0)) seg_c = 7'h7F;
`endif
  end

  // Only the low byte of each port is displayed.
  assign unused_hi_c = ^{out_port0[31:8], out_port1[31:8], out_port2[31:8], out_port3[31:8]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      dig         <= '0;
      snap        <= 32'h0;
      seg         <= 7'h7F;
      an          <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      if (tick_c) begin
        cnt <= '0;
        dig <= dig + DIG_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // Snapshot once per frame so a digit pair never tears.
      if (wrap_c) begin
        snap <= {out_port3[7:0], out_port2[7:0], out_port1[7:0], out_port0[7:0]};
      end
      frame_start <= wrap_c;
      if (blank_c) begin
        an  <= 8'hFF;
        seg <= 7'h7F;
      end else begin
        an  <= ~(8'b1 << dig);
        seg <= seg_c;
      end
    end
  end

endmodule

// File: tb/tb_io_seg_scan.sv
// Bench for io_seg_scan: cycle-count based reference model plus directed literal checks.
module tb_io_seg_scan;

  localparam int DIV_A = 4;
  localparam int BLK_A = 1;
  localparam int DIV_B = 2;
  localparam int BLK_B = 0;

  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] out_port0, out_port1, out_port2, out_port3;
  logic [6:0]  seg_a, seg_b;
  logic [7:0]  an_a, an_b;
  logic        fs_a, fs_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  io_seg_scan #(.CLK_DIV(DIV_A), .BLANK_CYC(BLK_A)) u_dut (
    .clock(clock), .resetn(resetn),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2), .out_port3(out_port3),
    .seg(seg_a), .an(an_a), .frame_start(fs_a)
  );

  io_seg_scan #(.CLK_DIV(DIV_B), .BLANK_CYC(BLK_B)) u_nb (
    .clock(clock), .resetn(resetn),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2), .out_port3(out_port3),
    .seg(seg_b), .an(an_b), .frame_start(fs_b)
  );

  // Reference: outputs after the n-th clock since reset follow directly from n.
  function automatic logic [7:0] an_of(input int n, input int div, input int blk);
    int slot, d;
    slot = n % div;
    d    = (n / div) % 8;
    if (slot < blk) return 8'hFF;
    return ~(8'b1 << d);
  endfunction

  function automatic logic [6:0] seg_of(input int n, input logic [31:0] s, input int div, input int blk);
    int slot, d;
    logic [3:0] nib;
    slot = n % div;
    d    = (n / div) % 8;
    if (slot < blk) return 7'h7F;
    nib = 4'(s >> (4 * d));
`ifdef SEG_LZB_EN
    if ((d % 2 == 1) && (nib == 4'h0)) return 7'h7F;
`endif
    return HEX[nib];
  endfunction

  logic [31:0] ports_c;
  assign ports_c = {out_port3[7:0], out_port2[7:0], out_port1[7:0], out_port0[7:0]};

  int          n_a, n_b;
  logic [31:0] snap_a, snap_b;
  logic [6:0]  eseg_a, eseg_b;
  logic [7:0]  ean_a, ean_b;
  logic        efs_a, efs_b;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      n_a <= 0; snap_a <= 32'h0; eseg_a <= 7'h7F; ean_a <= 8'hFF; efs_a <= 1'b0;
    end else begin
      eseg_a <= seg_of(n_a, snap_a, DIV_A, BLK_A);
      ean_a  <= an_of(n_a, DIV_A, BLK_A);
      efs_a  <= ((n_a % (8 * DIV_A)) == 8 * DIV_A - 1);
      if ((n_a % (8 * DIV_A)) == 8 * DIV_A - 1) snap_a <= ports_c;
      n_a <= n_a + 1;
    end
  end

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      n_b <= 0; snap_b <= 32'h0; eseg_b <= 7'h7F; ean_b <= 8'hFF; efs_b <= 1'b0;
    end else begin
      eseg_b <= seg_of(n_b, snap_b, DIV_B, BLK_B);
      ean_b  <= an_of(n_b, DIV_B, BLK_B);
      efs_b  <= ((n_b % (8 * DIV_B)) == 8 * DIV_B - 1);
      if ((n_b % (8 * DIV_B)) == 8 * DIV_B - 1) snap_b <= ports_c;
      n_b <= n_b + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("a_seg", 32'(seg_a), 32'(eseg_a));
    chk("a_an",  32'(an_a),  32'(ean_a));
    chk("a_fs",  32'(fs_a),  32'(efs_a));
    chk("b_seg", 32'(seg_b), 32'(eseg_b));
    chk("b_an",  32'(an_b),  32'(ean_b));
    chk("b_fs",  32'(fs_b),  32'(efs_b));
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_an(input string nm, input logic [7:0] tgt);
    for (int k = 0; k < 300 && an_a !== tgt; k++) step();
    chk(nm, 32'(an_a), 32'(tgt));
  endtask

  task automatic wait_fs(input string nm);
    for (int k = 0; k < 300 && fs_a !== 1'b1; k++) step();
    chk(nm, 32'(fs_a), 32'h1);
  endtask

  initial begin
    int c;
    int k;
    logic [7:0] first_an;
    resetn    = 1'b1;
    out_port0 = 32'hA5;
    out_port1 = 32'h12;
    out_port2 = 32'h0;
    out_port3 = 32'h0;
    #1 resetn = 1'b0;

    repeat (20) step();
    chk("rst_an",  32'(an_a),  32'hFF);
    chk("rst_seg", 32'(seg_a), 32'h7F);
    chk("rst_fs",  32'(fs_a),  32'h0);
    resetn = 1'b1;

    // First reload latches A5; digit0 shows 5, digit1 shows A.
    wait_fs("first_fs");
    step(); step();
    chk("slot0_an",  32'(an_a),  32'hFE);
    chk("slot0_seg", 32'(seg_a), 32'h12);
    repeat (4) step();
    chk("slot1_an",  32'(an_a),  32'hFD);
    chk("slot1_seg", 32'(seg_a), 32'h08);

    c = 0;
    repeat (64) begin
      step();
      if (fs_a === 1'b1) c++;
    end
    chk("fs_per_64", 32'(c), 32'd2);

    // Port change while digit3 is lit must not appear until the next reload.
    wait_an("tear_d3_reach", 8'hF7);
    chk("tear_d3_old", 32'(seg_a), 32'h79);
    out_port1 = 32'h3C;
    step();
    chk("tear_d3_hold_an",  32'(an_a),  32'hF7);
    chk("tear_d3_hold_seg", 32'(seg_a), 32'h79);
    wait_fs("tear_fs");
    wait_an("tear_d2_reach", 8'hFB);
    chk("tear_d2_new", 32'(seg_a), 32'h46);
    wait_an("tear_d3_reach2", 8'hF7);
    chk("tear_d3_new", 32'(seg_a), 32'h30);

    // Reset while dig=5, cnt=2.
    wait_an("mid_d5_reach", 8'hDF);
    resetn = 1'b0;
    #1;
    chk("mid_rst_an",  32'(an_a),  32'hFF);
    chk("mid_rst_seg", 32'(seg_a), 32'h7F);
    chk("mid_rst_fs",  32'(fs_a),  32'h0);
    out_port1 = 32'h07;
    repeat (3) step();
    resetn = 1'b1;
    first_an = 8'hFF;
    k = 0;
    do begin
      step();
      k++;
      if (first_an == 8'hFF && an_a !== 8'hFF) first_an = an_a;
    end while (fs_a !== 1'b1 && k < 100);
    chk("mid_first_an", 32'(first_an), 32'hFE);
    chk("mid_fs_delay", 32'(k), 32'd32);

    // Leading-zero handling for byte 0x07 on digits 3:2.
    wait_an("lzb_d2_reach", 8'hFB);
    chk("lzb_d2_seg", 32'(seg_a), 32'h78);
    wait_an("lzb_d3_reach", 8'hF7);
`ifdef SEG_LZB_EN
    chk("lzb_d3_seg", 32'(seg_a), 32'h7F);
`else
    chk("lzb_d3_seg", 32'(seg_a), 32'h40);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
